// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with HI/LO registers.
// A result is computed at launch, held in HI_tmp/LO_tmp, and committed
// to HI/LO only when the busy window ends.
// Optional build macro: MDU_DIVZERO_HOLD_EN.
// When it is defined, division by zero leaves HI/LO untouched.
// When it is not defined, division by zero commits HI=A and LO=all ones.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mt_en,
    output logic        busy,
    output logic [31:0] MDU_ans
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state;
    logic [31:0]        hi;
    logic [31:0]        lo;
    logic [31:0]        hi_tmp;
    logic [31:0]        lo_tmp;
    logic [CNT_W-1:0]   cnt;

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic [31:0]        div_den;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic [CNT_W-1:0]   load_cnt;

    // Compute the pending result for the requested op. The divisor is forced to 1 for /0 and for the signed overflow case,
    // so the divider never sees an undefined input. Dividing by 1 also yields the required 0x80000000 / 0 result for the overflow case.
    always_comb begin
        prod_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u   = {32'd0, A} * {32'd0, B};
        div_zero = (B == 32'd0);
        div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        div_den  = (div_zero || div_ovf) ? 32'd1 : B;
        quot_s   = $signed(A) / $signed(div_den);
        rem_s    = $signed(A) % $signed(div_den);
        quot_u   = A / div_den;
        rem_u    = A % div_den;
        res_hi   = prod_s[63:32];
        res_lo   = prod_s[31:0];
        case (MDUOp[1:0])
            2'd0: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            2'd1: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            2'd2: begin
                res_hi = rem_s;
                res_lo = quot_s;
            end
            default: begin
                res_hi = rem_u;
                res_lo = quot_u;
            end
        endcase
        if (MDUOp[1] && div_zero) begin
`ifdef MDU_DIVZERO_HOLD_EN
            res_hi = hi;
            res_lo = lo;
`else
            res_hi = A;
            res_lo = 32'hFFFF_FFFF;
`endif
        end
        load_cnt = MDUOp[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end

    // Control FSM: launch in IDLE, count down in RUN, and commit on the final busy edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            hi     <= 32'd0;
            lo     <= 32'd0;
            hi_tmp <= 32'd0;
            lo_tmp <= 32'd0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !MDUOp[2]) begin
                        hi_tmp <= res_hi;
                        lo_tmp <= res_lo;
                        cnt    <= load_cnt;
                        state  <= RUN;
                    end else if (mt_en && (MDUOp == 3'd4)) begin
                        lo <= A;
                    end else if (mt_en && (MDUOp == 3'd5)) begin
                        hi <= A;
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        hi    <= hi_tmp;
                        lo    <= lo_tmp;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);

    // Read port: only committed HI/LO are ever visible.
    always_comb begin
        case (MDUOp)
            3'd7:    MDU_ans = hi;
            3'd6:    MDU_ans = lo;
            default: MDU_ans = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed plus randomized bench for mult_div_unit.
// The reference model is written with plain 64-bit arithmetic.
// The model also tracks the commit edge, and it is checked against the DUT on every falling edge.
// Honours MDU_DIVZERO_HOLD_EN in the same way as the design.
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  MDUOp = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        mt_en = 1'b0;
    logic        busy;
    logic [31:0] MDU_ans;

    int checks = 0;
    int failures = 0;

    // Model state
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;
    logic        m_pending = 1'b0;
    int          edge_idx = 0;
    int          done_edge = 0;

    // Busy run-length monitor
    int run_len = 0;
    int last_run = 0;

    mult_div_unit #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .MDUOp  (MDUOp),
        .A      (A),
        .B      (B),
        .mt_en  (mt_en),
        .busy   (busy),
        .MDU_ans(MDU_ans)
    );

    always #5 clk = ~clk;

    // Architectural result of an op, as {HI, LO}
    function automatic logic [63:0] compute(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] cur_hi,
                                            input logic [31:0] cur_lo);
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned prod;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op == 3'd0) begin
            q = sa * sb;
            return q;
        end else if (op == 3'd1) begin
            prod = ua * ub;
            return prod;
        end else if (b == 32'd0) begin
`ifdef MDU_DIVZERO_HOLD_EN
            return {cur_hi, cur_lo};
`else
            return {a, 32'hFFFF_FFFF};
`endif
        end else if (op == 3'd2) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end else begin
            prod = ua / ub;
            ua   = ua % ub;
            return {ua[31:0], prod[31:0]};
        end
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic mt);
        @(posedge clk);
        #2;
        start = s;
        MDUOp = op;
        A     = a;
        B     = b;
        mt_en = mt;
    endtask

    task automatic launchOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        applyStimulus(1'b1, op, a, b, 1'b0);
        applyStimulus(1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic waitIdle();
        int guard = 0;
        @(negedge clk);
        #1;
        while (busy && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        checkOutput("wait_idle", {63'd0, busy}, 64'd0);
    endtask

    task automatic readReg(input logic [2:0] op, input string name, input logic [31:0] expected);
        MDUOp = op;
        #1;
        checkOutput(name, {32'd0, MDU_ans}, {32'd0, expected});
    endtask

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Reference model: commit N edges after the launch edge; mt writes only while idle
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi      <= 32'd0;
            m_lo      <= 32'd0;
            m_pending <= 1'b0;
            edge_idx  <= 0;
        end else begin
            edge_idx <= edge_idx + 1;
            if (m_pending) begin
                if (edge_idx == done_edge) begin
                    m_hi      <= p_hi;
                    m_lo      <= p_lo;
                    m_pending <= 1'b0;
                end
            end else if (start && MDUOp < 3'd4) begin
                m_pending    <= 1'b1;
                done_edge    <= edge_idx + ((MDUOp < 3'd2) ? MULT_N : DIV_N);
                {p_hi, p_lo} <= compute(MDUOp, A, B, m_hi, m_lo);
            end else if (mt_en && MDUOp == 3'd4) begin
                m_lo <= A;
            end else if (mt_en && MDUOp == 3'd5) begin
                m_hi <= A;
            end
        end
    end

    // Compare DUT against model every cycle
    always @(negedge clk) begin
        checkOutput("busy", {63'd0, busy}, {63'd0, m_pending});
        checkOutput("mdu_ans", {32'd0, MDU_ans},
                    {32'd0, (MDUOp == 3'd7) ? m_hi : ((MDUOp == 3'd6) ? m_lo : 32'd0)});
    end

    // Length of the most recent busy window
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            run_len  <= 0;
            last_run <= 0;
        end else if (busy) begin
            run_len <= run_len + 1;
        end else if (run_len != 0) begin
            last_run <= run_len;
            run_len  <= 0;
        end
    end

    initial begin
        // Pin the model with hand-computed values
        checkOutput("pin_mult", compute(3'd0, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0), 64'hFFFF_FFFF_FFFF_FFFA);
        checkOutput("pin_multu", compute(3'd1, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0), 64'h0000_0002_FFFF_FFFA);
        checkOutput("pin_div", compute(3'd2, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0), 64'hFFFF_FFFF_FFFF_FFFD);
        checkOutput("pin_div_ovf", compute(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0), 64'h0000_0000_8000_0000);
        checkOutput("pin_divu", compute(3'd3, 32'd7, 32'd2, 32'd0, 32'd0), 64'h0000_0001_0000_0003);

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        readReg(3'd6, "reset_lo", 32'd0);
        readReg(3'd7, "reset_hi", 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;

        $display("[TB] mult -2 * 3");
        launchOp(3'd0, 32'hFFFF_FFFE, 32'd3);
        waitIdle();
        checkOutput("mult_busy_len", 64'(last_run), 64'(MULT_N));
        readReg(3'd7, "mult_hi", 32'hFFFF_FFFF);
        readReg(3'd6, "mult_lo", 32'hFFFF_FFFA);

        $display("[TB] multu 0xFFFFFFFE * 3");
        launchOp(3'd1, 32'hFFFF_FFFE, 32'd3);
        waitIdle();
        checkOutput("multu_busy_len", 64'(last_run), 64'(MULT_N));
        readReg(3'd7, "multu_hi", 32'h0000_0002);
        readReg(3'd6, "multu_lo", 32'hFFFF_FFFA);

        $display("[TB] div -7 / 2");
        launchOp(3'd2, 32'hFFFF_FFF9, 32'd2);
        @(negedge clk);
        #1;
        checkOutput("div_busy_mid", {63'd0, busy}, 64'd1);
        checkOutput("mflo_during_busy", {32'd0, MDU_ans}, 64'h0000_0000_FFFF_FFFA);
        waitIdle();
        checkOutput("div_busy_len", 64'(last_run), 64'(DIV_N));
        readReg(3'd6, "div_lo", 32'hFFFF_FFFD);
        readReg(3'd7, "div_hi", 32'hFFFF_FFFF);

        $display("[TB] mthi then mfhi, then start during busy");
        applyStimulus(1'b0, 3'd5, 32'h1234_5678, 32'd0, 1'b1);
        applyStimulus(1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("mfhi_after_mthi", {32'd0, MDU_ans}, 64'h0000_0000_1234_5678);
        applyStimulus(1'b1, 3'd0, 32'd3, 32'd4, 1'b0);
        applyStimulus(1'b1, 3'd2, 32'd100, 32'd7, 1'b1);
        applyStimulus(1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
        waitIdle();
        checkOutput("restart_busy_len", 64'(last_run), 64'(MULT_N));
        readReg(3'd7, "restart_hi", 32'd0);
        readReg(3'd6, "restart_lo", 32'd12);

        $display("[TB] start with mf opcode is ignored");
        applyStimulus(1'b1, 3'd6, 32'd9, 32'd9, 1'b0);
        applyStimulus(1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("ignored_start_busy", {63'd0, busy}, 64'd0);

        $display("[TB] signed div overflow");
        launchOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        waitIdle();
        readReg(3'd6, "ovf_lo", 32'h8000_0000);
        readReg(3'd7, "ovf_hi", 32'd0);

        $display("[TB] divu by zero");
        applyStimulus(1'b0, 3'd5, 32'hAAAA_AAAA, 32'd0, 1'b1);
        applyStimulus(1'b0, 3'd4, 32'h5555_5555, 32'd0, 1'b1);
        launchOp(3'd3, 32'd5, 32'd0);
        waitIdle();
        checkOutput("divzero_busy_len", 64'(last_run), 64'(DIV_N));
`ifdef MDU_DIVZERO_HOLD_EN
        readReg(3'd7, "divzero_hi", 32'hAAAA_AAAA);
        readReg(3'd6, "divzero_lo", 32'h5555_5555);
`else
        readReg(3'd7, "divzero_hi", 32'd5);
        readReg(3'd6, "divzero_lo", 32'hFFFF_FFFF);
`endif

        $display("[TB] reset during div");
        launchOp(3'd2, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        readReg(3'd6, "abort_lo", 32'd0);
        readReg(3'd7, "abort_hi", 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (15) applyStimulus(1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
        #1;
        checkOutput("no_late_commit_busy", {63'd0, busy}, 64'd0);
        readReg(3'd7, "no_late_commit_hi", 32'd0);
        readReg(3'd6, "no_late_commit_lo", 32'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                          pickVal(), pickVal(), 1'($urandom_range(0, 1)));
        end
        applyStimulus(1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
        waitIdle();
        readReg(3'd7, "final_hi", m_hi);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, meaning busy duration in cycles for mult/multu.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, meaning busy duration in cycles for div/divu.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: launches mult/multu/div/divu; driven from the decoder's MDU_start.
REQ-006 The block SHALL have port MDUOp, input, 3 bits: 0 mult, 1 multu, 2 div, 3 divu, 4 mtlo, 5 mthi, 6 mflo, 7 mfhi.
REQ-007 The block SHALL have port A, input, 32 bits: rs operand, already forwarded.
REQ-008 The block SHALL have port B, input, 32 bits: rt operand, already forwarded.
REQ-009 The block SHALL have port mt_en, input, 1 bit: write strobe for mtlo/mthi, asserted in the stage holding mt.
REQ-010 The block SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-011 The block SHALL have port MDU_ans, output, 32 bits: mf read data.

Function
REQ-012 The block SHALL hold architectural registers HI and LO (32 bits each), plus pending registers HI_tmp/LO_tmp and a down-counter cnt.
REQ-013 The block SHALL use two states, IDLE (busy=0) and RUN (busy=1).
REQ-014 On a rising edge in IDLE with start=1 and MDUOp in 0..3, the block SHALL compute the result into HI_tmp/LO_tmp, load cnt with MULT_CYCLES or DIV_CYCLES, and enter RUN.
REQ-015 mult SHALL form the signed 64-bit product of A*B and multu the unsigned product; in both cases HI gets bits 63:32 and LO gets bits 31:0.
REQ-016 div SHALL produce the signed quotient in LO and the signed remainder in HI, truncating toward zero with the remainder taking the sign of the dividend; divu SHALL do the same unsigned.
REQ-017 In RUN, cnt SHALL decrement each edge; on the edge where cnt==1 the block SHALL copy HI_tmp/LO_tmp to HI/LO and return to IDLE.
REQ-018 busy SHALL be 1 for exactly N consecutive cycles following the start edge, where N is the cycle parameter for the operation, and the new HI/LO values SHALL be visible in the first cycle with busy=0.
REQ-019 While busy=1, the block SHALL ignore start and mt_en; the pipeline stalls on start|busy.
REQ-020 The block SHALL ignore start when MDUOp is 4..7.
REQ-021 In IDLE, mt_en=1 SHALL write A to LO when MDUOp=4 and to HI when MDUOp=5, on the same edge.
REQ-022 When start and mt_en are both asserted in the same IDLE cycle, start SHALL win.
REQ-023 MDU_ans SHALL be combinational: HI when MDUOp=7, LO when MDUOp=6, otherwise 0.
REQ-024 MDU_ans SHALL always reflect the committed HI/LO, never HI_tmp/LO_tmp.
REQ-025 Signed div with A=0x80000000 and B=0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0.

Reset
REQ-026 When reset=0, asynchronously and regardless of clk, the block SHALL clear HI, LO, HI_tmp, LO_tmp and cnt to 0 and set state to IDLE, so busy=0 and MDU_ans=0.
REQ-027 When reset is asserted during RUN, the block SHALL abort the operation and SHALL NOT commit the pending result.
REQ-028 The block SHALL leave reset on the first rising edge after reset returns to 1.

Configuration
REQ-029 The block SHALL provide the macro MDU_DIVZERO_HOLD_EN.
REQ-030 With MDU_DIVZERO_HOLD_EN defined, div/divu with B=0 SHALL still assert busy for DIV_CYCLES but SHALL leave HI and LO unchanged.
REQ-031 Without MDU_DIVZERO_HOLD_EN, div/divu with B=0 SHALL commit HI=A and LO=0xFFFFFFFF.

Verification
REQ-032 The bench SHALL cover: mult A=0xFFFFFFFE (-2), B=3 -> busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 The bench SHALL cover: multu A=0xFFFFFFFE, B=3 -> HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
REQ-034 The bench SHALL cover: div A=-7, B=2 -> busy high for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; mflo during busy returns the old LO.
REQ-035 The bench SHALL cover: mthi A=0x12345678 with mt_en=1 in IDLE, then mfhi -> MDU_ans=0x12345678; a second start during busy -> no effect and busy length unchanged.
REQ-036 The bench SHALL cover: start div, then reset=0 for 1 cycle at busy cycle 4 -> busy=0 immediately, HI=LO=0, and no later commit.
REQ-037 The bench SHALL cover: divu A=5, B=0 -> with the macro HI/LO unchanged; without it HI=5, LO=0xFFFFFFFF.
